// File: rtl/push_button_pkg.sv
// Shared types and helpers for the push-button input peripheral.
package push_button_pkg;

  localparam int unsigned IO_DATA_WIDTH = 16;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } db_state_e;

  // Counter width for a debounce window; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/push_button_if.sv
// Pin/bus bundle between board inputs, CPU read mux and the push-button peripheral.
interface push_button_if import push_button_pkg::*; #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0]         ext_button;
  logic [IO_DATA_WIDTH-1:0] ack;
  logic [IO_DATA_WIDTH-1:0] data;
  logic [IO_DATA_WIDTH-1:0] evt;

  modport master (output ext_button, output ack, input data, input evt);
  modport slave  (input ext_button, input ack, output data, output evt);
endinterface

// File: rtl/debounce_bit.sv
// One input: 2-FF synchronizer, polarity normalization and counter-based debounce.
module debounce_bit import push_button_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise_c
);

  localparam int unsigned    CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          s;
  logic          deb_q;
  logic [CW-1:0] cnt_q;
  db_state_e     state_q;

  // Synchronizer resets to the released pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= {2{ACTIVE_LOW}};
    else        sync_q <= {sync_q[0], pin};
  end

  assign s = sync_q[1] ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
    end else begin
      case (state_q)
        STABLE: begin
          if (s != deb_q) begin
            state_q <= COUNTING;
            cnt_q   <= CW'(1);
          end else begin
            cnt_q   <= '0;
          end
        end
        COUNTING: begin
          if (s == deb_q) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == TERM) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            deb_q   <= ~deb_q;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level  = deb_q;
  // High in the cycle whose closing edge accepts a press.
  assign rise_c = (state_q == COUNTING) && s && !deb_q && (cnt_q == TERM);

endmodule

// File: rtl/push_button_in.sv
// Debounced push-button/DIP input port with zero-extended level word.
// PUSH_BUTTON_EVENT_EN builds the sticky press-event register with ack clearing.
module push_button_in import push_button_pkg::*; #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  push_button_if.slave bus
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise_c;
  logic             unused_ack;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .pin    (bus.ext_button[i]),
      .level  (level[i]),
      .rise_c (rise_c[i])
    );
  end

  assign bus.data = IO_DATA_WIDTH'(level);

`ifdef PUSH_BUTTON_EVENT_EN
  logic [WIDTH-1:0] evt_q;

  // A press in the same cycle as its ack wins so no event is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) evt_q <= '0;
    else        evt_q <= rise_c | (evt_q & ~bus.ack[WIDTH-1:0]);
  end

  assign bus.evt    = IO_DATA_WIDTH'(evt_q);
  assign unused_ack = ^bus.ack;
`else
  assign bus.evt    = '0;
  assign unused_ack = ^{bus.ack, rise_c};
`endif

endmodule

// File: tb/tb_push_button_in.sv
// Scoreboard bench for push_button_in (WIDTH=4, DEBOUNCE_CYCLES=8, ACTIVE_LOW=1).
// Expected event values collapse to zero when PUSH_BUTTON_EVENT_EN is undefined.
module tb_push_button_in;

`ifdef PUSH_BUTTON_EVENT_EN
  localparam bit EV = 1'b1;
`else
  localparam bit EV = 1'b0;
`endif

  typedef struct {
    int unsigned at;
    logic [15:0] d;
    logic [15:0] ev;
    string       nm;
  } exp_t;

  logic        clk;
  logic        reset;
  int unsigned edges;
  int unsigned checks;
  int unsigned failures;
  exp_t        sb[$];

  push_button_if #(.WIDTH(4)) bus ();

  push_button_in #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (8),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial edges = 0;
  always @(posedge clk) edges <= edges + 1;

  // Insert keeping the queue ordered by target edge.
  task automatic expect_at(input int unsigned at, input logic [15:0] d,
                           input logic [15:0] ev, input string nm);
    exp_t x;
    int   pos;
    x.at = at;
    x.d  = d;
    x.ev = EV ? ev : 16'h0000;
    x.nm = nm;
    pos  = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].at > at) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: compares registered outputs mid-cycle against due scoreboard entries.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= edges) begin
      exp_t x;
      x = sb.pop_front();
      if (x.at < edges) begin
        checks++;
        failures++;
        $display("FAIL %s missed: due edge %0d, now edge %0d", x.nm, x.at, edges);
      end else begin
        checks++;
        if (bus.data !== x.d) begin
          failures++;
          $display("FAIL %s data @edge %0d: got %h want %h", x.nm, edges, bus.data, x.d);
        end
        checks++;
        if (bus.evt !== x.ev) begin
          failures++;
          $display("FAIL %s event @edge %0d: got %h want %h", x.nm, edges, bus.evt, x.ev);
        end
      end
    end
  end

  initial begin
    int unsigned e;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.ext_button = 4'b0000;
    bus.ack        = 16'h0000;

    // Held in reset with all buttons pressed
    tick(1);
    for (int i = 0; i < 4; i++) expect_at(edges + i, 16'h0, 16'h0, "in_reset");
    tick(4);
    reset = 1'b1;
    e = edges;
    expect_at(e + 9,  16'h0, 16'h0, "rst_rel_early");
    expect_at(e + 10, 16'hF, 16'hF, "rst_rel_press");
    tick(12);

    // Release all; events stay sticky
    bus.ext_button = 4'b1111;
    e = edges;
    expect_at(e + 9,  16'hF, 16'hF, "rel_early");
    expect_at(e + 10, 16'h0, 16'hF, "rel_done");
    tick(12);
    bus.ack = 16'h000F;
    expect_at(edges + 1, 16'h0, 16'h0, "ack_all");
    tick(1);
    bus.ack = 16'h0000;
    tick(2);

    // Clean press and release of bit 0
    bus.ext_button = 4'b1110;
    e = edges;
    expect_at(e + 9,  16'h0, 16'h0, "press_early");
    expect_at(e + 10, 16'h1, 16'h1, "press");
    tick(12);
    bus.ext_button = 4'b1111;
    e = edges;
    expect_at(e + 9,  16'h1, 16'h1, "rel_hold");
    expect_at(e + 10, 16'h0, 16'h1, "rel_evt_sticky");
    tick(12);

    // Ack of unimplemented bits is ignored, then real ack
    bus.ack = 16'hFFF0;
    expect_at(edges + 1, 16'h0, 16'h1, "ack_upper");
    tick(1);
    bus.ack = 16'h0001;
    expect_at(edges + 1, 16'h0, 16'h0, "ack_bit0");
    tick(1);
    bus.ack = 16'h0000;
    tick(1);

    // Bounce on bit 1 shorter than the debounce window
    for (int k = 0; k < 10; k++) begin
      bus.ext_button = (k % 2 == 0) ? 4'b1101 : 4'b1111;
      for (int j = 1; j <= 3; j++) expect_at(edges + j, 16'h0, 16'h0, "bounce");
      tick(3);
    end
    bus.ext_button = 4'b1111;
    for (int j = 1; j <= 12; j++) expect_at(edges + j, 16'h0, 16'h0, "bounce_settle");
    tick(13);

    // Ack collides with the edge that accepts a press of bit 2
    bus.ext_button = 4'b1011;
    e = edges;
    expect_at(e + 9,  16'h0, 16'h0, "coll_early");
    expect_at(e + 10, 16'h4, 16'h4, "coll_press");
    expect_at(e + 11, 16'h4, 16'h4, "coll_hold");
    tick(9);
    bus.ack = 16'h0004;
    tick(1);
    bus.ack = 16'h0000;
    tick(2);
    bus.ext_button = 4'b1111;
    tick(11);
    bus.ack = 16'h0004;
    expect_at(edges + 1, 16'h0, 16'h0, "coll_clear");
    tick(1);
    bus.ack = 16'h0000;

    // Bit 0 pressed and acked, then reset mid-count on bit 3
    bus.ext_button = 4'b1110;
    e = edges;
    expect_at(e + 10, 16'h1, 16'h1, "pre_mid");
    tick(11);
    bus.ack = 16'h0001;
    expect_at(edges + 1, 16'h1, 16'h0, "pre_mid_ack");
    tick(1);
    bus.ack = 16'h0000;
    bus.ext_button = 4'b0110;
    tick(7);
    reset = 1'b0;
    expect_at(edges, 16'h0, 16'h0, "mid_reset");
    tick(2);
    reset = 1'b1;
    e = edges;
    expect_at(e + 9,  16'h0, 16'h0, "recount_early");
    expect_at(e + 10, 16'h9, 16'h9, "recount");
    tick(12);

    for (int i = 0; i < 100 && sb.size() > 0; i++) tick(1);
    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL %s timeout: never reached edge %0d (now %0d)", x.nm, x.at, edges);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/push_button_in.md
# push_button_in

Debounced push-button / DIP-switch input peripheral: the read-side counterpart of the LED output port. Asynchronous external pins are synchronized, debounced per bit, and presented to the CPU bus as a 16-bit level word. Optional sticky press-event flags support a read-and-acknowledge handshake. The block sits between the board input pins and the CPU I/O read mux.

## Interface
- WIDTH, 4: number of physical inputs, 1..16.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a change (1 ms at 50 MHz); must be ≥ 2.
- ACTIVE_LOW, 1: 1 means pin low = pressed.

- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- ext_button  in  WIDTH  raw board pins, asynchronous to clk.
- ack  in  16  event clear mask, one-cycle pulse per bit; bits ≥ WIDTH ignored.
- data  out  16  debounced pressed level; bit i = 1 when input i is pressed; upper bits 0.
- event  out  16  sticky press flags; upper bits 0.

## Operation
- Reset values (while reset = 0):
  - sync stages hold the released pin level;
  - debounce counters = 0;
  - data = 0 and event = 0.
- Per bit:
  - 2-FF synchronizer, then polarity normalization (invert when ACTIVE_LOW = 1) to give `s`.
- Per-bit debounce, as two states:
  - STABLE: `s` == debounced value. The counter is held at 0.
  - COUNTING: `s` != debounced value. The counter increments every cycle.
    - If `s` returns equal to the debounced value, the counter clears to 0 and the state returns to STABLE.
    - When the counter == DEBOUNCE_CYCLES-1 and `s` still differs, the debounced value toggles and the counter clears.
- Counter width: clog2(DEBOUNCE_CYCLES). The counter never wraps, because it clears at the terminal count.
- Event (press) logic:
  - Set event[i] on a debounced 0→1 transition.
  - Clear event[i] when ack[i] = 1.
  - If set and ack occur in the same cycle, set wins, so no press is lost.
  - Release (1→0) never sets or clears event.
- Inputs already pressed when reset deasserts are accepted as a fresh press after the normal debounce latency, and they set event.

## Timing
- Pin-to-data latency is 2 + DEBOUNCE_CYCLES clk edges after the pin settles, assuming setup is met at the first sync FF.
- event asserts on the same edge that data rises.
- ack takes effect on the next edge; event reads 0 one cycle after the ack pulse.
- data and event are registered outputs with no combinational path from any input.
- Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles is rejected.
- Reset asserted mid-count aborts the count immediately, because the reset is asynchronous. Counting restarts from 0 after reset deasserts.

## Configuration
- PUSH_BUTTON_EVENT_EN defined: the sticky event register and ack handling are built as described above.
- PUSH_BUTTON_EVENT_EN undefined:
  - the event register is not instantiated;
  - event is tied to 16'h0000;
  - ack is ignored;
  - data behaviour is unchanged.

## Structure
- Shared package push_button_pkg contains:
  - IO_DATA_WIDTH = 16;
  - the counter-width helper (clog2);
  - the debounce state encoding (STABLE, COUNTING).
- Sub-module debounce_bit holds the synchronizer, polarity normalization, counter, and debounced register for one input. It is instantiated WIDTH times by a generate loop.
- Event/ack logic and the zero-extension to 16 bits live in the top module.

## Test plan
All scenarios use WIDTH = 4, DEBOUNCE_CYCLES = 8, ACTIVE_LOW = 1.
- Reset: reset = 0 with ext_button = 4'b0000 → data = 0, event = 0 throughout reset. Release reset → data = 0x000F and event = 0x000F exactly 10 edges later.
- Clean press: ext_button 4'b1111 → 4'b1110 held → data = 0x0001 and event = 0x0001 on edge 10. Release to 4'b1111 → data = 0x0000 10 edges later, event still 0x0001.
- Bounce rejection: toggle bit 1 every 3 cycles for 30 cycles, then return it high → data and event remain 0x0000 throughout.
- Ack handshake: with event = 0x0001, pulse ack = 0x0001 for one cycle → event = 0x0000 on the next edge, data unchanged. Ack = 0xFFF0 → no effect.
- Collision: drive ack[2] = 1 on the exact edge that a press of bit 2 completes → event[2] = 1 afterward.
- Reset mid-count: assert reset at counter = 5 → data = 0 immediately, then recount 10 edges after release. Second build without PUSH_BUTTON_EVENT_EN → event = 0x0000 in all scenarios, data identical to the first build.
